// File: rtl/vscpu_pkg.sv
// Shared definitions for the multi-wait-state VSCPU core.
//   opcode_t  : 4-bit opcode, {op[2:0], imm}
//   state_t   : access-sequencer states
//   data_w()  : instruction/data width derived from the address width
//   ir_*()    : instruction field extraction for any ADDR_W up to MAX_ADDR_W
package vscpu_pkg;

  // Upper bound on ADDR_W supported by the field-extraction helpers.
  localparam int unsigned MAX_ADDR_W = 30;
  localparam int unsigned MAX_DATA_W = 4 + 2 * MAX_ADDR_W;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_ADDI   = 4'b0001,
    OP_NAND   = 4'b0010,
    OP_NANDI  = 4'b0011,
    OP_SRL    = 4'b0100,
    OP_SRLI   = 4'b0101,
    OP_LT     = 4'b0110,
    OP_LTI    = 4'b0111,
    OP_CP     = 4'b1000,
    OP_CPI    = 4'b1001,  // CPi : *A = B
    OP_CPIND  = 4'b1010,  // CPI : *A = *(*B)
    OP_CPINDI = 4'b1011,  // CPIi: *(*A) = *B
    OP_BZJ    = 4'b1100,
    OP_BZJI   = 4'b1101,
    OP_MUL    = 4'b1110,
    OP_MULI   = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_RDA,
    S_RDB,
    S_RDI,
    S_WR
  } state_t;

  function automatic int unsigned data_w(input int unsigned addr_w);
    return 4 + 2 * addr_w;
  endfunction

  // Callers zero-extend the instruction word to MAX_DATA_W.
  function automatic opcode_t ir_opcode(input logic [MAX_DATA_W-1:0] ir,
                                        input int unsigned addr_w);
    return opcode_t'(4'(ir >> (2 * addr_w)));
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] ir_field_a(input logic [MAX_DATA_W-1:0] ir,
                                                       input int unsigned addr_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = ~({MAX_ADDR_W{1'b1}} << addr_w);
    return MAX_ADDR_W'(ir >> addr_w) & mask;
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] ir_field_b(input logic [MAX_DATA_W-1:0] ir,
                                                       input int unsigned addr_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = ~({MAX_ADDR_W{1'b1}} << addr_w);
    return MAX_ADDR_W'(ir) & mask;
  endfunction

endpackage

// File: rtl/vscpu_alu.sv
// Combinational VSCPU ALU: ADD, NAND, SRL, LT, MUL (register and immediate
// opcodes alike; the caller substitutes the immediate into b).
//   op : opcode
//   a  : first operand (*A)
//   b  : second operand (*B or zero-extended B)
//   y  : result
module vscpu_alu
  import vscpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W-1:0] DW_V = DATA_W'(DATA_W);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD, OP_ADDI:   y = a + b;
      OP_NAND, OP_NANDI: y = ~(a & b);
      // Shift amounts past DATA_W turn into a left shift; >= 2*DATA_W gives 0.
      OP_SRL, OP_SRLI: begin
        if (b < DW_V) y = a >> b;
        else          y = a << (b - DW_V);
      end
      OP_LT, OP_LTI:     y = DATA_W'(a < b);
      OP_MUL, OP_MULI:   y = a * b;
      default:           y = '0;
    endcase
  end

endmodule

// File: rtl/vscpu_mw_core.sv
// Multi-cycle VSCPU core with a req/ack memory port tolerating any number of
// wait states. Memory-port outputs depend only on registered state.
//   clk, rst            : clock, synchronous active-high reset
//   mem_req/we/addr/wdata : access request, held until mem_ack
//   mem_ack, mem_rdata  : access completion and read data
//   pc                  : program counter
//   retire              : one-cycle pulse after each completed instruction
module vscpu_mw_core
  import vscpu_pkg::*;
#(
  parameter  int unsigned ADDR_W = 14,
  localparam int unsigned DATA_W = data_w(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              retire
);

  state_t            state_q, state_d;
  logic              active_q;
  logic [DATA_W-1:0] ir_q, op_a_q, op_b_q;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              retire_q, done, acked;
  opcode_t           cur_op, fetch_op;
  logic [ADDR_W-1:0] fa, fb, addr_c;
  logic [DATA_W-1:0] imm_ext, alu_b, alu_y, wdata_c;
  logic              we_c;

  assign cur_op   = ir_opcode(MAX_DATA_W'(ir_q), ADDR_W);
  assign fetch_op = ir_opcode(MAX_DATA_W'(mem_rdata), ADDR_W);
  assign fa       = ADDR_W'(ir_field_a(MAX_DATA_W'(ir_q), ADDR_W));
  assign fb       = ADDR_W'(ir_field_b(MAX_DATA_W'(ir_q), ADDR_W));
  assign imm_ext  = DATA_W'(fb);
  assign alu_b    = cur_op[0] ? imm_ext : op_b_q;
  assign acked    = active_q & mem_ack;
  assign pc_inc   = pc_q + ADDR_W'(1);

  vscpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op (cur_op),
    .a  (op_a_q),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Access address / data for the current state.
  always_comb begin
    addr_c  = pc_q;
    we_c    = 1'b0;
    wdata_c = alu_y;
    case (state_q)
      S_FETCH: addr_c = pc_q;
      S_RDA:   addr_c = fa;
      S_RDB:   addr_c = fb;
      S_RDI:   addr_c = ADDR_W'(op_b_q);
      S_WR: begin
        we_c   = 1'b1;
        addr_c = (cur_op == OP_CPINDI) ? ADDR_W'(op_a_q) : fa;
        case (cur_op)
          OP_CP, OP_CPIND, OP_CPINDI: wdata_c = op_b_q;
          OP_CPI:                     wdata_c = imm_ext;
          default:                    wdata_c = alu_y;
        endcase
      end
      default: addr_c = pc_q;
    endcase
  end

  // Sequencing: the FETCH decision decodes the arriving instruction word;
  // later states decode the latched IR.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done    = 1'b0;
    if (acked) begin
      case (state_q)
        S_FETCH: begin
          case (fetch_op)
            OP_CP, OP_CPIND: state_d = S_RDB;
            OP_CPI:          state_d = S_WR;
            default:         state_d = S_RDA;
          endcase
        end
        S_RDA: begin
          case (cur_op)
            OP_BZJI: begin
              done = 1'b1;
              pc_d = ADDR_W'(mem_rdata) + fb;
            end
            OP_ADDI, OP_NANDI, OP_SRLI, OP_LTI, OP_MULI: state_d = S_WR;
            default: state_d = S_RDB;
          endcase
        end
        S_RDB: begin
          case (cur_op)
            OP_BZJ: begin
              done = 1'b1;
              pc_d = (mem_rdata == '0) ? ADDR_W'(op_a_q) : pc_inc;
            end
            OP_CPIND: state_d = S_RDI;
            default:  state_d = S_WR;
          endcase
        end
        S_RDI: state_d = S_WR;
        S_WR: begin
          done = 1'b1;
          pc_d = pc_inc;
        end
        default: state_d = S_FETCH;
      endcase
      if (done) state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      active_q <= 1'b0;
      ir_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      pc_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      state_q  <= state_d;
      pc_q     <= pc_d;
      retire_q <= done;
      if (acked) begin
        case (state_q)
          S_FETCH:      ir_q   <= mem_rdata;
          S_RDA:        op_a_q <= mem_rdata;
          S_RDB, S_RDI: op_b_q <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

  // active_q keeps the port idle during the reset cycle itself.
  assign mem_req   = active_q;
  assign mem_we    = active_q & we_c;
  assign mem_addr  = active_q ? addr_c : '0;
  assign mem_wdata = (active_q & we_c) ? wdata_c : '0;
  assign pc        = pc_q;
  assign retire    = retire_q;

endmodule

// File: tb/tb_vscpu_mw_core.sv
// Scoreboard bench for vscpu_mw_core: a wait-state memory model, expected
// writes/retirements queued by directed tests, monitors pop and compare.
module tb_vscpu_mw_core;

  localparam int AW = 14;
  localparam int DW = 32;

  localparam logic [3:0] ADD = 4'h0, ADDI = 4'h1, NAND = 4'h2, SRL = 4'h4, SRLI = 4'h5,
                         LT = 4'h6, LTI = 4'h7, CP = 4'h8, CPIM = 4'h9, CPI = 4'hA,
                         CPII = 4'hB, BZJ = 4'hC, BZJI = 4'hD, MUL = 4'hE, MULI = 4'hF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, retire;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  vscpu_mw_core #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .pc        (pc),
    .retire    (retire)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [AW-1:0] pc; int lat; } ret_t;

  wr_t  exp_wr[$];
  ret_t exp_ret[$];

  int n_checks = 0;
  int n_err    = 0;
  int waits    = 0;
  int wcnt     = 0;
  int cyc      = 0;
  logic armed  = 1'b0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] enc(input logic [3:0] op, input int a, input int b);
    return {op, 14'(a), 14'(b)};
  endfunction

  // Memory model: ack after `waits` stall cycles; reset wins over a write.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= waits) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      wcnt++;
    end
  end

  logic          hold = 1'b0;
  logic [AW-1:0] h_addr;
  logic          h_we;
  logic [DW-1:0] h_wdata;

  // Write monitor and wait-state snapshot.
  always @(posedge clk) begin
    wr_t e;
    if (armed && !rst && mem_req && mem_ack && mem_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
    hold    = armed && !rst && mem_req && !mem_ack;
    h_addr  = mem_addr;
    h_we    = mem_we;
    h_wdata = mem_wdata;
    if (mem_req && mem_ack && !rst) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      wcnt = 0;
    end
  end

  // Retire monitor, latency counter and stall-stability check.
  always @(negedge clk) begin
    ret_t r;
    if (armed) begin
      cyc++;
      if (hold)
        check("wait_stable", 64'({mem_addr, mem_we, mem_wdata}), 64'({h_addr, h_we, h_wdata}));
      if (retire) begin
        if (exp_ret.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_retire: pc 0x%0h, none expected", pc);
        end else begin
          r = exp_ret.pop_front();
          check("ret_pc", 64'(pc), 64'(r.pc));
          check("ret_cycles", 64'(cyc - 1), 64'(r.lat));
        end
        cyc = 1;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  endtask

  task automatic exp_w(input int a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = 14'(a);
    e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic exp_r(input int p, input int accesses);
    ret_t r;
    r.pc  = 14'(p);
    r.lat = accesses * (waits + 1);
    exp_ret.push_back(r);
  endtask

  task automatic check_reset_outputs();
    check("reset_outputs", 64'({mem_req, mem_we, mem_addr, mem_wdata, pc, retire}), 64'(0));
  endtask

  task automatic do_reset();
    armed = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    cyc   = 0;
    armed = 1'b1;
  endtask

  task automatic run_prog();
    int b;
    do_reset();
    b = 3000;
    while (exp_ret.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("all_retired", 64'(exp_ret.size()), 64'(0));
    check("all_written", 64'(exp_wr.size()), 64'(0));
    armed = 1'b0;
    rst   = 1'b1;
    exp_ret.delete();
    exp_wr.delete();
  endtask

  task automatic load_add();
    clear_mem();
    mem[0]  = enc(ADD, 10, 11);
    mem[10] = 32'd5;
    mem[11] = 32'd7;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;

    // Reset state and first fetch.
    clear_mem();
    waits = 0;
    do_reset();
    @(negedge clk);
    check("first_fetch", 64'({mem_req, mem_we, mem_addr, pc}), 64'({1'b1, 1'b0, 14'd0, 14'd0}));
    armed = 1'b0;
    rst   = 1'b1;

    // ADD, zero wait.
    load_add();
    waits = 0;
    exp_w(10, 32'd12);
    exp_r(1, 4);
    run_prog();

    // ADD, three wait cycles per access.
    load_add();
    waits = 3;
    exp_w(10, 32'd12);
    exp_r(1, 4);
    run_prog();

    // SRL right branch, SRLi left branch.
    clear_mem();
    waits = 0;
    mem[0]  = enc(SRL, 10, 11);
    mem[1]  = enc(SRLI, 12, 33);
    mem[10] = 32'h8000_0000;
    mem[11] = 32'd4;
    mem[12] = 32'd1;
    exp_w(10, 32'h0800_0000); exp_r(1, 4);
    exp_w(12, 32'd2);         exp_r(2, 3);
    run_prog();

    // BZJ taken.
    clear_mem();
    waits = 0;
    mem[0]  = enc(BZJ, 12, 13);
    mem[12] = 32'h2A;
    mem[13] = 32'd0;
    exp_r(32'h2A, 3);
    run_prog();

    // BZJi to top of memory, then BZJ not taken wraps pc to 0.
    clear_mem();
    waits = 0;
    mem[0]       = enc(BZJI, 5, 0);
    mem[5]       = 32'h3FFF;
    mem[14'h3FFF] = enc(BZJ, 6, 7);
    mem[6]       = 32'h1234;
    mem[7]       = 32'd1;
    exp_r(14'h3FFF, 2);
    exp_r(0, 3);
    run_prog();

    // BZJi sum truncation.
    clear_mem();
    waits = 0;
    mem[0] = enc(BZJI, 5, 2);
    mem[5] = 32'h3FFF;
    exp_r(1, 2);
    run_prog();

    // CPI and CPIi.
    clear_mem();
    waits = 0;
    mem[0]  = enc(CPI, 15, 20);
    mem[1]  = enc(CPII, 16, 17);
    mem[20] = 32'd30;
    mem[30] = 32'd99;
    mem[16] = 32'd40;
    mem[17] = 32'h1234;
    exp_w(15, 32'd99);   exp_r(1, 4);
    exp_w(40, 32'h1234); exp_r(2, 4);
    run_prog();

    // Mixed opcodes with one wait cycle per access.
    clear_mem();
    waits = 1;
    mem[0]  = enc(NAND, 10, 11);
    mem[1]  = enc(LTI, 12, 100);
    mem[2]  = enc(MULI, 13, 3);
    mem[3]  = enc(CPIM, 14, 14'h3ABC);
    mem[4]  = enc(CP, 15, 12);
    mem[5]  = enc(ADDI, 10, 1);
    mem[6]  = enc(LT, 16, 17);
    mem[7]  = enc(MUL, 18, 19);
    mem[10] = 32'hF0F0_F0F0;
    mem[11] = 32'hFF00_FF00;
    mem[12] = 32'd99;
    mem[13] = 32'h8000_0001;
    mem[16] = 32'd5;
    mem[17] = 32'd3;
    mem[18] = 32'h0001_0000;
    mem[19] = 32'h0001_0001;
    exp_w(10, 32'h0FFF_0FFF); exp_r(1, 4);
    exp_w(12, 32'd1);         exp_r(2, 3);
    exp_w(13, 32'h8000_0003); exp_r(3, 3);
    exp_w(14, 32'h3ABC);      exp_r(4, 2);
    exp_w(15, 32'd1);         exp_r(5, 3);
    exp_w(10, 32'h0FFF_1000); exp_r(6, 3);
    exp_w(16, 32'd0);         exp_r(7, 4);
    exp_w(18, 32'h0001_0000); exp_r(8, 4);
    run_prog();

    // Self-modifying code: instruction 0 rewrites instruction 1.
    clear_mem();
    waits = 0;
    mem[0]  = enc(CP, 1, 20);
    mem[1]  = enc(ADDI, 10, 100);
    mem[20] = enc(ADDI, 10, 5);
    exp_w(1, enc(ADDI, 10, 5)); exp_r(1, 3);
    exp_w(10, 32'd5);           exp_r(2, 3);
    run_prog();

    // Reset during the RDB stall: no write or retire, restart at fetch 0.
    load_add();
    waits = 3;
    do_reset();
    b = 200;
    while (!(mem_req && !mem_we && mem_addr == 14'd11) && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("reach_rdb", 64'(b > 0), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("refetch_after_reset", 64'({mem_req, mem_we, mem_addr, pc}), 64'({1'b1, 1'b0, 14'd0, 14'd0}));
    armed = 1'b0;
    rst   = 1'b1;
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vscpu_mw_core.md
# vscpu_mw_core

Parametrised multi-cycle VerySimpleCPU core with a request/acknowledge memory port that tolerates any number of wait states. It executes the 16-opcode VSCPU instruction set: ADD, NAND, SRL, LT, CP, CPI, BZJ and MUL, each in register and immediate form. All memory outputs are driven from registered state only, so there is no combinational path from `mem_rdata` or `mem_ack` to any output. It replaces the fixed 14-bit, zero-wait core between the instruction/data RAM and the SoC top level.

## Interface
- `ADDR_W`, default 14: address width, and also the width of each instruction operand field.
- `DATA_W`, derived localparam, value 4+2*ADDR_W (32 at the default): memory word and instruction width.
- `clk` in 1: the single clock. Everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_req` out 1: access request. Held high until it is acknowledged.
- `mem_we` out 1: 1 means write, 0 means read. Valid while `mem_req` is high.
- `mem_addr` out ADDR_W: access address.
- `mem_wdata` out DATA_W: write data. Valid while `mem_req` and `mem_we` are both high.
- `mem_ack` in 1: completes the current access in the cycle it is sampled high. Ignored when `mem_req` is low.
- `mem_rdata` in DATA_W: read data. Valid only in a cycle where `mem_ack` is high.
- `pc` out ADDR_W: current program counter.
- `retire` out 1: one-cycle pulse for each completed instruction.

## Operation
- **Instruction format:** opcode in [DATA_W-1:DATA_W-4], made up of op[2:0] followed by the imm bit. Field A is the next ADDR_W bits; field B is [ADDR_W-1:0].
- **Opcode encodings:** ADD=000, NAND=001, SRL=010, LT=011, CP=100, CPI=101, BZJ=110, MUL=111.
- **Notation:** *X means mem[X]. The immediate B is zero-extended to DATA_W.
- **Instruction semantics:**
  - ADD/ADDi: *A = *A + *B (or + B).
  - NAND/NANDi: *A = ~(*A & opnd).
  - MUL/MULi: *A = low DATA_W bits of *A × opnd.
  - LT/LTi: *A = (*A < opnd) ? 1 : 0, unsigned compare.
  - SRL/SRLi: *A = (opnd < DATA_W) ? *A >> opnd : *A << (opnd − DATA_W). A result of 0 when opnd ≥ 2·DATA_W is acceptable and falls out naturally.
  - CP: *A = *B. CPi: *A = B.
  - CPI: *A = *(*B). CPIi: *(*A) = *B. Pointers are truncated to ADDR_W.
  - BZJ: pc = (*B == 0) ? *A : pc+1.
  - BZJi: pc = *A + B, truncated to ADDR_W.
  - Every other instruction sets pc = pc+1, modulo 2^ADDR_W.
- **States:**
  - FETCH: read mem[pc].
  - RDA: read mem[A], or mem[*A-ptr] where applicable.
  - RDB: read mem[B].
  - RDI: read the indirect target.
  - WR: write.
- **Access sequence per opcode, in order:**
  - ADD, NAND, SRL, LT, MUL: FETCH, RDA, RDB, WR.
  - Their immediate forms: FETCH, RDA, WR.
  - CP: FETCH, RDB, WR. CPi: FETCH, WR.
  - CPI: FETCH, RDB, RDI (address = *B), WR (address A).
  - CPIi: FETCH, RDA, RDB, WR (address = *A).
  - BZJ: FETCH, RDA, RDB. BZJi: FETCH, RDA. Neither writes.
- **State transitions:** each state holds, with `mem_req` high and the address, data and `mem_we` stable, until `mem_ack`. On ack the core latches `mem_rdata` into the instruction register, op_a or op_b as appropriate and moves to the next state.
- **Instruction completion:** on ack of an instruction's final access, pc updates and the core returns to FETCH.
- **Result computation:** the write data is computed from the registered op_a/op_b/IR, never from `mem_rdata`.

## Timing
- **Reset:** in the cycle after `rst` is sampled high, the outputs are:
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `pc`=0, `retire`=0;
  - state=FETCH, with the instruction and operand registers cleared.
- **After reset:** in the first cycle after `rst` drops, `mem_req` is high with `mem_addr`=0.
- **Reset mid-access:** the outstanding request is dropped with no completion. The memory must tolerate an unacked request being withdrawn. No write is issued after reset.
- **Zero-wait memory** (`mem_ack` tied high): one access per cycle, with no idle cycle between instructions.
  - ADD: 4 cycles. ADDi: 3. CPi: 2. CPI: 4. BZJi: 2.
- **N wait cycles per access:** each access takes N+1 cycles.
- **`retire`:** registered, high in the cycle after the final ack. That cycle is also the first cycle of the next FETCH.
- **`pc`:** updates in the same edge as the final ack, so the next FETCH address is already correct.
- **Write ordering:** the write for instruction k completes before fetch k+1 is issued, so self-modifying code works.
- **Simultaneous `rst` and `mem_ack`:** reset wins and the access is discarded.

## Structure
- **Package `vscpu_pkg`:**
  - opcode enum (4-bit, including the imm bit);
  - state enum;
  - field-extraction functions parametrised by ADDR_W;
  - the DATA_W derivation.
- **Sub-module `vscpu_alu`:** combinational; takes opcode, op_a and op_b and returns the result. It covers ADD, NAND, SRL, LT and MUL; the immediate substitution is done by the caller.
- **Core:** the FSM, registers and port drivers.

## Test plan
- **Reset and first fetch:** after a reset pulse, the cycle after `rst` falls shows `mem_req`=1, `mem_addr`=0, `mem_we`=0; `pc`=0.
- **ADD, zero-wait:** mem[10]=5, mem[11]=7, ADD A=10 B=11 at pc 0. Required: 4 cycles, then a write of 12 to address 10 with `mem_we`=1; `pc`=1; `retire` pulses once.
- **Wait states:** the same program with `mem_ack` delayed 3 cycles per access. Required: outputs stable throughout each wait, and completion in 16 cycles with an identical result.
- **SRL both branches:** *A=0x80000000 with *B=4 gives 0x08000000. *A=1 with SRLi B=33 gives 2.
- **Branches and wrap:**
  - BZJ with *B=0, *A=0x2A gives `pc`=0x2A.
  - BZJ with *B≠0 at pc 0x3FFF gives `pc`=0 (wrap).
  - BZJi with *A=0x3FFF, B=2 gives `pc`=1.
- **Indirect and reset mid-op:**
  - CPI: mem[20]=30, mem[30]=99 writes 99 to A.
  - CPIi: *A=40 writes *B to address 40.
  - `rst` asserted during RDB stall: no write follows, and the next request is a fetch at address 0.
